// File: rtl/definitions_pkg.sv
// definitions_pkg: shared types and constants for the data-memory responder
package definitions_pkg;
  localparam int DMEM_ADDR_W = 12;
  typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, TURN} dmem_state_e;
  function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
    return (size == MEM_H && off[0]) || (size == MEM_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: load lane select with sign/zero extension, store lane replication and byte enables
module dmem_load_align import definitions_pkg::*; (
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        uns,
  input  logic [31:0] word,
  output logic [31:0] load_data,
  input  logic [31:0] store_in,
  output logic [31:0] store_data,
  output logic [3:0]  be
);
  logic [7:0]  b;
  logic [15:0] h;
  // offending low address bits are simply ignored here, which force-aligns halves and words
  always_comb begin
    b          = word[{off, 3'b000} +: 8];
    h          = off[1] ? word[31:16] : word[15:0];
    load_data  = size == MEM_B ? {{24{b[7] & ~uns}}, b} :
                 size == MEM_H ? {{16{h[15] & ~uns}}, h} : word;
    store_data = size == MEM_B ? {4{store_in[7:0]}} :
                 size == MEM_H ? {2{store_in[15:0]}} : store_in;
    be         = size == MEM_B ? 4'b0001 << off :
                 size == MEM_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-laned SRAM responder on the shared load/store bus with wait states; DMEM_MISALIGN_TRAP_EN enables the misalignment trap
module dmem_responder import definitions_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [DMEM_ADDR_W-1:0] addr,
  input  logic                   we,
  input  mem_size_e              size,
  input  logic                   uns,
  inout  tri   [31:0]            ls_data,
  output logic                   ready,
  output logic                   err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);
  dmem_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DMEM_ADDR_W-1:0] addr_r;
  logic we_r, uns_r;
  mem_size_e size_r;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [31:0] word, load_data, store_data;
  logic [3:0] be;
  logic live, trap, drive, wr;
  logic unused_addr;
  assign idx = addr_r[2 +: IW];
  assign unused_addr = ^addr_r;
  assign word = mem[idx];
  assign live = req & (state == RESPOND);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = misaligned(size_r, addr_r[1:0]);
  assign err = live & trap;
`else
  assign trap = 1'b0;
  assign err = 1'b0;
`endif
  assign ready = live;
  assign drive = live & ~we_r;
  assign wr = live & we_r & ~trap;
  assign ls_data = drive ? (trap ? 32'h0 : load_data) : 'z;
  dmem_load_align u_align (
    .off(addr_r[1:0]),
    .size(size_r),
    .uns(uns_r),
    .word(word),
    .load_data(load_data),
    .store_in(ls_data),
    .store_data(store_data),
    .be(be)
  );
  // state, wait counter and captured request; reset drops any pending access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_r <= '0;
      we_r   <= 1'b0;
      size_r <= MEM_B;
      uns_r  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        addr_r <= addr;
        we_r   <= we;
        size_r <= size;
        uns_r  <= uns;
      end
    end
  end
  // next state: accept in IDLE only, count wait states, abort when req drops early
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (req) begin
        state_n = WAIT_STATES > 0 ? WAIT : RESPOND;
        cnt_n   = CNT_INIT;
      end
      WAIT: if (!req) state_n = TURN;
            else if (cnt == 4'd0) state_n = RESPOND;
            else cnt_n = cnt - 4'd1;
      RESPOND: state_n = TURN;
      default: state_n = IDLE;
    endcase
  end
  // byte-lane SRAM write at the responding edge; contents are never reset
  always_ff @(posedge clk) begin
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responder configurations against a byte-level memory model
module tb_dmem_responder;
  import definitions_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req, den, ready, err;
  logic [11:0] addr;
  logic we, uns;
  mem_size_e size;
  logic [31:0] drv, rd;
  tri [31:0] bus0, bus1;
  logic [31:0] model [2][1024];
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  assign bus0 = den[0] ? drv : 'z;
  assign bus1 = den[1] ? drv : 'z;
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .addr(addr), .we(we), .size(size),
    .uns(uns), .ls_data(bus0), .ready(ready[0]), .err(err[0]));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .addr(addr), .we(we), .size(size),
    .uns(uns), .ls_data(bus1), .ready(ready[1]), .err(err[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int ws(input int d);
    return d ? 3 : 0;
  endfunction
  function automatic int wi(input int d, input logic [11:0] a);
    return int'(a[11:2]) % (d ? 256 : 1024);
  endfunction
  function automatic logic mis(input mem_size_e sz, input logic [11:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (sz == MEM_H && a[0]) || (sz == MEM_W && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic released(input int d);
    logic [31:0] b;
    b = d ? bus1 : bus0;
    return $isunknown(b) || b == 32'h0;
  endfunction
  function automatic logic [31:0] m_load(input int d, input logic [11:0] a, input mem_size_e sz, input logic u);
    logic [31:0] w, v;
    int sh;
    w = model[d][wi(d, a)];
    if (mis(sz, a)) return 32'h0;
    if (sz == MEM_B) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hff;
      if (!u && v > 32'd127) v = v + 32'hffffff00;
      return v;
    end
    if (sz == MEM_H) begin
      sh = a[1] ? 16 : 0;
      v = (w >> sh) & 32'hffff;
      if (!u && v > 32'd32767) v = v + 32'hffff0000;
      return v;
    end
    return w;
  endfunction
  function automatic void m_store(input int d, input logic [11:0] a, input mem_size_e sz, input logic [31:0] wd);
    int lo, n, lane;
    logic [31:0] w, byt;
    if (mis(sz, a)) return;
    lo = sz == MEM_B ? int'(a[1:0]) : sz == MEM_H ? (a[1] ? 2 : 0) : 0;
    n = sz == MEM_B ? 1 : sz == MEM_H ? 2 : 4;
    w = model[d][wi(d, a)];
    for (int k = 0; k < n; k++) begin
      lane = lo + k;
      byt = (wd >> (8 * k)) & 32'hff;
      w = (w & ~(32'hff << (8 * lane))) | (byt << (8 * lane));
    end
    model[d][wi(d, a)] = w;
  endfunction
  // mode: 0 normal, 1 keep req high through TURN, 2 abort in WAIT, 3 reset in RESPOND
  task automatic op(input int d, input logic [11:0] a, input logic w, input mem_size_e sz,
                    input logic u, input logic [31:0] wd, input int mode, output logic [31:0] rdata);
    int n;
    logic [31:0] exp;
    exp = m_load(d, a, sz, u);
    rdata = '0;
    addr = a; we = w; size = sz; uns = u; drv = wd;
    req = '0; req[d] = 1'b1;
    den = '0; den[d] = w;
    @(posedge clk);
    if (mode == 2) begin
      @(negedge clk);
      chk("abort_wait_rdy", 32'(ready[d]), 32'd0);
      req = '0; den = '0;
      @(negedge clk);
      chk("abort_turn_rdy", 32'(ready[d]), 32'd0);
      chk("abort_turn_bus", 32'(released(d)), 32'd1);
      @(negedge clk);
      return;
    end
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready[d]) break;
      if (!w) chk("wait_bus", 32'(released(d)), 32'd1);
    end
    chk("latency", n, ws(d) + 1);
    chk("err", 32'(err[d]), 32'(mis(sz, a)));
    if (mode == 3) begin
      rst_n = 1'b0;
      #1;
      chk("rst_rdy", 32'(ready[d]), 32'd0);
      chk("rst_err", 32'(err[d]), 32'd0);
      if (!w) chk("rst_bus", 32'(released(d)), 32'd1);
      req = '0; den = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    rdata = d ? bus1 : bus0;
    if (!w) chk("load", rdata, exp);
    else m_store(d, a, sz, wd);
    @(negedge clk);
    chk("turn_rdy", 32'(ready[d]), 32'd0);
    if (mode != 1) req = '0;
    den = '0;
    #1;
    chk("turn_bus", 32'(released(d)), 32'd1);
    @(negedge clk);
    if (mode == 1) chk("idle_rdy", 32'(ready[d]), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    req = '0; den = '0; addr = '0; we = 1'b0; size = MEM_B; uns = 1'b0; drv = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_bus0", 32'(released(0)), 32'd1);
    chk("reset_bus1", 32'(released(1)), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) op(0, 12'(i * 4), 1'b1, MEM_W, 1'b0, 32'h0, 0, rd);
    for (int i = 0; i < 256; i++) op(1, 12'(i * 4), 1'b1, MEM_W, 1'b0, 32'h0, 0, rd);
    op(0, 12'h010, 1'b1, MEM_W, 1'b0, 32'hDEADBEEF, 0, rd);
    op(0, 12'h010, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("w010", rd, 32'hDEADBEEF);
    op(0, 12'h021, 1'b1, MEM_B, 1'b0, 32'h55555580, 0, rd);
    op(0, 12'h022, 1'b1, MEM_H, 1'b0, 32'h77771234, 0, rd);
    op(0, 12'h020, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("w020", rd, 32'h12348000);
    op(0, 12'h021, 1'b0, MEM_B, 1'b0, 32'h0, 0, rd);
    chk("b021_signed", rd, 32'hFFFFFF80);
    op(0, 12'h021, 1'b0, MEM_B, 1'b1, 32'h0, 0, rd);
    chk("b021_unsigned", rd, 32'h00000080);
    op(0, 12'h020, 1'b0, MEM_H, 1'b0, 32'h0, 0, rd);
    chk("h020_signed", rd, 32'hFFFF8000);
    op(0, 12'h022, 1'b0, MEM_H, 1'b0, 32'h0, 0, rd);
    chk("h022_signed", rd, 32'h00001234);
    op(1, 12'h100, 1'b1, MEM_W, 1'b0, 32'hCAFEF00D, 1, rd);
    op(1, 12'h100, 1'b0, MEM_W, 1'b0, 32'h0, 1, rd);
    chk("w100_ws3", rd, 32'hCAFEF00D);
    op(1, 12'h040, 1'b1, MEM_W, 1'b0, 32'h2468ACE0, 0, rd);
    op(1, 12'h040, 1'b1, MEM_W, 1'b0, 32'h13579BDF, 2, rd);
    op(1, 12'h040, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("abort_keeps_old", rd, 32'h2468ACE0);
    op(1, 12'h100, 1'b0, MEM_W, 1'b0, 32'h0, 3, rd);
    op(1, 12'h100, 1'b1, MEM_W, 1'b0, 32'h0BADF00D, 3, rd);
    op(1, 12'h100, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("reset_drops_store", rd, 32'hCAFEF00D);
    op(1, 12'h404, 1'b1, MEM_W, 1'b0, 32'h600DCAFE, 0, rd);
    op(1, 12'h004, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("wrap_alias", rd, 32'h600DCAFE);
`ifdef DMEM_MISALIGN_TRAP_EN
    op(0, 12'h013, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("trap_load_zero", rd, 32'h0);
    op(0, 12'h011, 1'b1, MEM_H, 1'b0, 32'h0000FFFF, 0, rd);
    op(0, 12'h010, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("trap_no_write", rd, 32'hDEADBEEF);
`else
    op(0, 12'h013, 1'b0, MEM_W, 1'b0, 32'h0, 0, rd);
    chk("force_align_load", rd, 32'hDEADBEEF);
`endif
    for (int i = 0; i < 300; i++) begin
      automatic int d = int'($urandom_range(0, 1));
      op(d, 12'($urandom), 1'($urandom), mem_size_e'(2'($urandom_range(0, 2))), 1'($urandom),
         $urandom, int'($urandom_range(0, 1)), rd);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
